// File: rtl/display_frame_ctrl_if.sv
// Byte-stream input and display-side outputs of the frame controller.
// The master side (receiver/bench) drives the stream; the slave side is the controller.
interface display_frame_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       clear;
  logic [7:0] out1;
  logic [7:0] out2;
  logic [7:0] out3;
  logic       busy;
  logic       frame_done;
  logic       frame_err;

  modport master (
    output rx_data, rx_valid, clear,
    input  out1, out2, out3, busy, frame_done, frame_err
  );

  modport slave (
    input  rx_data, rx_valid, clear,
    output out1, out2, out3, busy, frame_done, frame_err
  );
endinterface

// File: rtl/display_frame_ctrl.sv
// Sync-byte framed receiver: gathers three payload bytes in shadows and commits
// them to the decoder inputs on a single edge; stalled partial frames time out.
module display_frame_ctrl #(
  parameter logic [7:0]  SYNC_BYTE = 8'hAA,
  parameter int unsigned TIMEOUT   = 5_000_000,
  parameter int unsigned TO_W      = 23
) (
  input  logic                clk,
  input  logic                rst_n,
  display_frame_ctrl_if.slave bus
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, GET1, GET2, GET3} state_t;

  state_t          r_state, w_state_nxt;
  logic [TO_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [7:0]      r_sh1, r_sh2, w_sh1_nxt, w_sh2_nxt;
  logic [7:0]      r_out1, r_out2, r_out3, w_out1_nxt, w_out2_nxt, w_out3_nxt;
  logic            r_busy, r_done, r_err, w_done_nxt, w_err_nxt;
  logic            w_expire;

  // State, shadows, counter and all outputs share one register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sh1   <= '0;
      r_sh2   <= '0;
      r_out1  <= '0;
      r_out2  <= '0;
      r_out3  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sh1   <= w_sh1_nxt;
      r_sh2   <= w_sh2_nxt;
      r_out1  <= w_out1_nxt;
      r_out2  <= w_out2_nxt;
      r_out3  <= w_out3_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Saturating idle count; expiry is the idle cycle that brings it to TIMEOUT-1
  assign w_cnt_inc = (r_cnt == TO_LAST) ? r_cnt : r_cnt + TO_W'(1);
  assign w_expire  = (w_cnt_inc == TO_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sh1_nxt   = r_sh1;
    w_sh2_nxt   = r_sh2;
    w_out1_nxt  = r_out1;
    w_out2_nxt  = r_out2;
    w_out3_nxt  = r_out3;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;

    if (bus.clear) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      w_sh1_nxt   = '0;
      w_sh2_nxt   = '0;
      w_out1_nxt  = '0;
      w_out2_nxt  = '0;
      w_out3_nxt  = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.rx_valid && (bus.rx_data == SYNC_BYTE)) begin
            w_state_nxt = GET1;
            w_cnt_nxt   = '0;
          end
        end
        GET1, GET2: begin
          if (bus.rx_valid) begin
            w_cnt_nxt = '0;
            if (r_state == GET1) begin
              w_sh1_nxt   = bus.rx_data;
              w_state_nxt = GET2;
            end else begin
              w_sh2_nxt   = bus.rx_data;
              w_state_nxt = GET3;
            end
          end else if (w_expire) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_sh1_nxt   = '0;
            w_sh2_nxt   = '0;
            w_err_nxt   = 1'b1;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        GET3: begin
          if (bus.rx_valid) begin
            w_out1_nxt  = r_sh1;
            w_out2_nxt  = r_sh2;
            w_out3_nxt  = bus.rx_data;
            w_done_nxt  = 1'b1;
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else if (w_expire) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_sh1_nxt   = '0;
            w_sh2_nxt   = '0;
            w_err_nxt   = 1'b1;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign bus.out1       = r_out1;
  assign bus.out2       = r_out2;
  assign bus.out3       = r_out3;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_done;
  assign bus.frame_err  = r_err;

endmodule

// File: tb/tb_display_frame_ctrl.sv
// Self-checking bench for display_frame_ctrl with a short timeout and a
// queue-based frame model that counts idle cycles since the last accepted byte.
module tb_display_frame_ctrl;

  localparam int unsigned TO  = 8;
  localparam logic [7:0]  SYN = 8'hAA;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cyc;

  display_frame_ctrl_if bus ();

  display_frame_ctrl #(.SYNC_BYTE(SYN), .TIMEOUT(TO), .TO_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic       m_in_frame;
  logic [7:0] m_pay[$];
  int         m_idle;
  logic [7:0] m_out1, m_out2, m_out3;
  logic       m_busy, m_done, m_err;

  task automatic m_reset();
    m_in_frame = 1'b0;
    m_pay.delete();
    m_idle = 0;
    m_out1 = 8'h00; m_out2 = 8'h00; m_out3 = 8'h00;
    m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
  endtask

  task automatic m_update(input logic [7:0] d, input logic v, input logic c);
    m_done = 1'b0;
    m_err  = 1'b0;
    if (c) begin
      m_in_frame = 1'b0;
      m_pay.delete();
      m_idle = 0;
      m_out1 = 8'h00; m_out2 = 8'h00; m_out3 = 8'h00;
    end else if (!m_in_frame) begin
      if (v && d == SYN) begin
        m_in_frame = 1'b1;
        m_idle = 0;
      end
    end else if (v) begin
      m_pay.push_back(d);
      m_idle = 0;
      if (m_pay.size() == 3) begin
        m_out1 = m_pay[0]; m_out2 = m_pay[1]; m_out3 = m_pay[2];
        m_done = 1'b1;
        m_pay.delete();
        m_in_frame = 1'b0;
      end
    end else begin
      m_idle++;
      if (m_idle == int'(TO) - 1) begin
        m_err = 1'b1;
        m_in_frame = 1'b0;
        m_pay.delete();
        m_idle = 0;
      end
    end
    m_busy = m_in_frame;
  endtask

  // Drive one cycle of input, advance through the edge, sample 1 time unit later
  task automatic step(input logic [7:0] d, input logic v, input logic c);
    bus.rx_data  = d;
    bus.rx_valid = v;
    bus.clear    = c;
    @(posedge clk);
    m_update(d, v, c);
    cyc++;
    #1;
    bus.rx_valid = 1'b0;
    bus.clear    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.rx_data = 8'h00; bus.rx_valid = 1'b0; bus.clear = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.out1, bus.out2, bus.out3, bus.busy, bus.frame_done, bus.frame_err} !== 27'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h/%h/%h b%b d%b e%b want all 0", bus.out1, bus.out2, bus.out3,
               bus.busy, bus.frame_done, bus.frame_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [7:0] seq [4];
    int busy_cnt;
    seq = '{8'hAA, 8'h12, 8'h34, 8'h56};
    busy_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step(seq[i], 1'b1, 1'b0);
      if (bus.busy === 1'b1) busy_cnt++;
    end
    checks++;
    if ({bus.out1, bus.out2, bus.out3, bus.frame_done, bus.busy} !== {8'h12, 8'h34, 8'h56, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL basic_commit got %h %h %h d%b b%b want 12 34 56 d1 b0", bus.out1, bus.out2, bus.out3,
               bus.frame_done, bus.busy);
    end
    step(8'h00, 1'b0, 1'b0);
    checks++;
    if (bus.frame_done !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_width got %b want 0", bus.frame_done);
    end
    checks++;
    if (busy_cnt != 3) begin
      errors++;
      $display("FAIL basic_busy_cycles got %0d want 3", busy_cnt);
    end
  endtask

  task automatic test_sync_payload();
    logic [7:0] seq [6];
    seq = '{8'h00, 8'hFF, 8'hAA, 8'hAA, 8'hAA, 8'h01};
    for (int i = 0; i < 6; i++) step(seq[i], 1'b1, 1'b0);
    checks++;
    if ({bus.out1, bus.out2, bus.out3, bus.frame_done} !== {8'hAA, 8'hAA, 8'h01, 1'b1}) begin
      errors++;
      $display("FAIL sync_payload got %h %h %h d%b want aa aa 01 d1", bus.out1, bus.out2, bus.out3,
               bus.frame_done);
    end
  endtask

  task automatic test_timeout();
    int err_at;
    int err_cnt;
    err_at = -1;
    err_cnt = 0;
    step(SYN, 1'b1, 1'b0);
    step(8'h77, 1'b1, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      step(8'h00, 1'b0, 1'b0);
      if (bus.frame_err === 1'b1) begin
        err_cnt++;
        err_at = k;
      end
    end
    checks++;
    if (err_cnt != 1 || err_at != int'(TO) - 1) begin
      errors++;
      $display("FAIL timeout_pulse got count %0d at idle step %0d want count 1 at %0d", err_cnt, err_at,
               int'(TO) - 1);
    end
    checks++;
    if ({bus.out1, bus.out2, bus.out3, bus.busy} !== {8'hAA, 8'hAA, 8'h01, 1'b0}) begin
      errors++;
      $display("FAIL timeout_hold got %h %h %h b%b want aa aa 01 b0", bus.out1, bus.out2, bus.out3, bus.busy);
    end
  endtask

  task automatic test_expiry_byte();
    int err_cnt;
    err_cnt = 0;
    step(SYN, 1'b1, 1'b0);
    step(8'h77, 1'b1, 1'b0);
    for (int k = 1; k < int'(TO) - 1; k++) begin
      step(8'h00, 1'b0, 1'b0);
      if (bus.frame_err === 1'b1) err_cnt++;
    end
    step(8'h88, 1'b1, 1'b0);
    if (bus.frame_err === 1'b1) err_cnt++;
    checks++;
    if (err_cnt != 0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL expiry_accept got errs %0d busy %b want errs 0 busy 1", err_cnt, bus.busy);
    end
    step(8'h99, 1'b1, 1'b0);
    checks++;
    if ({bus.out1, bus.out2, bus.out3, bus.frame_done, bus.frame_err} !== {8'h77, 8'h88, 8'h99, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL expiry_commit got %h %h %h d%b e%b want 77 88 99 d1 e0", bus.out1, bus.out2, bus.out3,
               bus.frame_done, bus.frame_err);
    end
  endtask

  task automatic test_clear();
    logic [7:0] seq [7];
    seq = '{8'hAA, 8'h12, 8'h34, 8'h56, 8'hAA, 8'h9A, 8'hBC};
    for (int i = 0; i < 7; i++) step(seq[i], 1'b1, 1'b0);
    step(8'hDE, 1'b1, 1'b1);
    checks++;
    if ({bus.out1, bus.out2, bus.out3, bus.busy, bus.frame_done, bus.frame_err} !== 27'd0) begin
      errors++;
      $display("FAIL clear_mid got %h %h %h b%b d%b e%b want all 0", bus.out1, bus.out2, bus.out3,
               bus.busy, bus.frame_done, bus.frame_err);
    end
    step(8'h00, 1'b0, 1'b0);
    checks++;
    if ({bus.out1, bus.out2, bus.out3, bus.frame_done} !== 25'd0) begin
      errors++;
      $display("FAIL clear_after got %h %h %h d%b want 0", bus.out1, bus.out2, bus.out3, bus.frame_done);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] seq [7];
    seq = '{8'hAA, 8'h55, 8'h66, 8'h77, 8'hAA, 8'h11, 8'h22};
    for (int i = 0; i < 7; i++) step(seq[i], 1'b1, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    m_reset();
    checks++;
    if ({bus.out1, bus.out2, bus.out3, bus.busy, bus.frame_done, bus.frame_err} !== 27'd0) begin
      errors++;
      $display("FAIL async_reset got %h %h %h b%b want all 0", bus.out1, bus.out2, bus.out3, bus.busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(8'h01, 1'b1, 1'b0);
    step(8'h02, 1'b1, 1'b0);
    step(SYN, 1'b1, 1'b0);
    step(8'h01, 1'b1, 1'b0);
    step(8'h02, 1'b1, 1'b0);
    step(8'h03, 1'b1, 1'b0);
    checks++;
    if ({bus.out1, bus.out2, bus.out3, bus.frame_done} !== {8'h01, 8'h02, 8'h03, 1'b1}) begin
      errors++;
      $display("FAIL post_reset_frame got %h %h %h d%b want 01 02 03 d1", bus.out1, bus.out2, bus.out3,
               bus.frame_done);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [8];
    int done_cyc[$];
    seq = '{8'hAA, 8'h01, 8'h02, 8'h03, 8'hAA, 8'h04, 8'h05, 8'h06};
    for (int i = 0; i < 9; i++) begin
      if (i < 8) step(seq[i], 1'b1, 1'b0);
      else       step(8'h00, 1'b0, 1'b0);
      if (bus.frame_done === 1'b1) done_cyc.push_back(cyc);
    end
    checks++;
    if (done_cyc.size() != 2 || (done_cyc[1] - done_cyc[0]) != 4) begin
      errors++;
      $display("FAIL b2b_pulses got %0d pulses spacing %0d want 2 spacing 4", done_cyc.size(),
               (done_cyc.size() == 2) ? done_cyc[1] - done_cyc[0] : -1);
    end
    checks++;
    if ({bus.out1, bus.out2, bus.out3} !== {8'h04, 8'h05, 8'h06}) begin
      errors++;
      $display("FAIL b2b_final got %h %h %h want 04 05 06", bus.out1, bus.out2, bus.out3);
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic v, c;
    int quiet;
    int bad;
    quiet = 0;
    bad = 0;
    for (int i = 0; i < 600; i++) begin
      if (quiet == 0 && $urandom_range(0, 24) == 0) quiet = $urandom_range(5, 12);
      if (quiet > 0) begin
        v = 1'b0;
        quiet--;
      end else begin
        v = ($urandom_range(0, 9) < 7);
      end
      d = ($urandom_range(0, 3) == 0) ? SYN : 8'($urandom);
      c = ($urandom_range(0, 59) == 0);
      step(d, v, c);
      checks++;
      if ({bus.out1, bus.out2, bus.out3, bus.busy, bus.frame_done, bus.frame_err} !==
          {m_out1, m_out2, m_out3, m_busy, m_done, m_err}) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL random_cycle%0d got %h %h %h b%b d%b e%b want %h %h %h b%b d%b e%b", i,
                   bus.out1, bus.out2, bus.out3, bus.busy, bus.frame_done, bus.frame_err,
                   m_out1, m_out2, m_out3, m_busy, m_done, m_err);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    test_reset();
    test_basic();
    test_sync_payload();
    test_timeout();
    test_expiry_byte();
    test_clear();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/display_frame_ctrl.md
# display_frame_ctrl

Frame controller between the serial receiver and the hex display decoder. It takes the receiver's byte stream and finds a sync byte. It collects the three payload bytes that follow into shadow registers, then commits them to the three decoder inputs in one clock, so the six digits never show a half-updated frame. Partial frames that stall past a timeout are discarded and flagged.

## Interface
Parameters:
- SYNC_BYTE, 8'hAA, header value that opens a frame
- TIMEOUT, 5_000_000, max idle clk cycles between bytes inside a frame (≥2)
- TO_W, 23, width of timeout counter (must hold TIMEOUT-1)

Ports:
- clk  in  1  system clock; all logic rising-edge
- rst_n  in  1  asynchronous, active-low reset; one clock domain only
- rx_data  in  8  received byte, valid only while rx_valid=1
- rx_valid  in  1  single-cycle strobe, one per received byte
- clear  in  1  synchronous clear of displayed value and frame state
- out1  out  8  decoder input 1 (digits 1–2), registered
- out2  out  8  decoder input 2 (digits 3–4), registered
- out3  out  8  decoder input 3 (digits 5–6), registered
- busy  out  1  high while a frame is partially received
- frame_done  out  1  one-cycle pulse, asserted in the cycle the new outN values first appear
- frame_err  out  1  one-cycle pulse on timeout abort

## Operation
- States: IDLE, GET1, GET2, GET3.
- IDLE:
  - rx_valid & rx_data==SYNC_BYTE -> GET1.
  - Any other byte is discarded. No error is raised.
- GET1: rx_valid -> shadow1<=rx_data, go to GET2.
- GET2: rx_valid -> shadow2<=rx_data, go to GET3.
- GET3: rx_valid -> commit, then go to IDLE:
  - out1<=shadow1, out2<=shadow2, out3<=rx_data, all in the same edge.
  - frame_done<=1 on that edge.
- Inside a frame, a byte equal to SYNC_BYTE is payload. There is no resync mid-frame.
- Timeout counter:
  - Cleared on entering GET1 and on every accepted byte. Increments each cycle in GET1–GET3 without rx_valid.
  - When it reaches TIMEOUT-1 with no rx_valid that cycle: go to IDLE, drop shadows, pulse frame_err.
  - outN keep their previous frame.
- rx_valid in the same cycle the timeout expires: the byte is accepted and there is no error.
- clear has priority over everything. On the next edge:
  - outN<=0, state<=IDLE, counter<=0.
  - No frame_done or frame_err pulse.
  - A byte presented in the same cycle is dropped.
- busy = (state != IDLE), registered with the state.
- The counter saturates; it never wraps. Its width is TO_W and it is unsigned.

## Timing
- Reset (rst_n=0, asynchronous):
  - out1=out2=out3=8'h00, busy=0, frame_done=0, frame_err=0.
  - state=IDLE, shadows=0, counter=0.
- Release of rst_n takes effect on the first clk edge after deassertion. The first frame can then be accepted immediately.
- Latency: 3rd payload byte strobed in cycle N -> outN updated and frame_done=1 in cycle N+1. busy drops in N+1.
- Minimum frame length is 4 consecutive cycles, with rx_valid back-to-back. Back-to-back frames are supported with no gap cycle.
- Timeout: last accepted byte in cycle N and no further rx_valid -> frame_err=1 and busy=0 in cycle N+TIMEOUT.
- frame_done and frame_err are never high together. Each lasts exactly one cycle.
- Reset asserted mid-frame: immediate return to reset values. The partial frame is lost.

## Test plan
- Reset -> all outputs 0. Send AA,12,34,56 back-to-back:
  - out1=12, out2=34, out3=56 and frame_done=1 all appear in the cycle after byte 56.
  - busy is high for exactly 3 cycles.
- Send 00,FF,AA,AA,AA,01 -> 00 and FF are ignored. The frame is AA header followed by payload AA,AA,01; out=AA,AA,01.
- TIMEOUT=8: send AA,77 then stop -> frame_err is high 8 cycles after 77, outN unchanged, busy=0.
- Repeat with a byte arriving exactly at expiry -> the byte is accepted and there is no frame_err.
- With out=12,34,56, send AA,9A,BC, then clear in the cycle of the last byte DE -> outN=00,00,00, state IDLE, no frame_done.
- Send AA,11,22, assert rst_n=0 asynchronously mid-clock -> outputs are 0 immediately. After release, AA,01,02,03 displays 01,02,03.
- Two back-to-back frames, AA,01,02,03,AA,04,05,06 -> frame_done pulses twice, 4 cycles apart. Final out=04,05,06.
